// File: rtl/bs_alu_arbiter.sv
// Round-robin arbiter that shares one bit-serial ALU between NREQ requesters.
// One op in flight at a time: latch, start pulse, wait for done or timeout, respond.
module bs_alu_arbiter #(
    parameter int NREQ    = 2,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_result,
    output logic              rsp_err,
    output logic              alu_start,
    output logic [3:0]        alu_op,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    input  logic [W-1:0]      alu_result,
    input  logic              alu_done,
    output logic              busy,
    output logic [1:0]        grant_id
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    grant_id_q, grant_id_d;
    logic          busy_q, busy_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    alu_op_q, alu_op_d;
    logic [W-1:0]  alu_a_q, alu_a_d;
    logic [W-1:0]  alu_b_q, alu_b_d;
    logic [W-1:0]  rsp_result_q, rsp_result_d;
    logic          rsp_err_q, rsp_err_d;

    logic          win_found;
    logic [1:0]    win_id;
    logic [3:0]    sel_op;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;
    logic          owner_rsp_ready;

    // Scan from the requester after the last owner, wrapping; first valid wins.
    always_comb begin : arb
        int cand;
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_q) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!win_found && (i == cand) && req_valid[i]) begin
                    win_found = 1'b1;
                    win_id    = 2'(i);
                end
            end
        end
    end

    always_comb begin
        sel_op          = '0;
        sel_a           = '0;
        sel_b           = '0;
        owner_rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (2'(i) == win_id) begin
                sel_op = req_op[4*i +: 4];
                sel_a  = req_a[W*i +: W];
                sel_b  = req_b[W*i +: W];
            end
            if (2'(i) == grant_id_q) begin
                owner_rsp_ready = rsp_ready[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_q       <= 2'(NREQ - 1);
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
            timer_q      <= '0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
            timer_q      <= timer_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        grant_id_d   = grant_id_q;
        timer_d      = timer_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    alu_op_d   = sel_op;
                    alu_a_d    = sel_a;
                    alu_b_d    = sel_b;
                    grant_id_d = win_id;
                    last_d     = win_id;
                    state_d    = ISSUE;
                end
            end
            // A done seen here belongs to the previous op, so it is not looked at.
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    state_d      = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                    state_d      = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // req_ready is gated by rstn so every output reads zero while reset is held.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        alu_start = (state_q == ISSUE);
        if (rstn && (state_q == IDLE) && win_found) begin
            req_ready = NREQ'(1) << win_id;
        end
        if (state_q == RESP) begin
            for (int i = 0; i < NREQ; i++) begin
                if (2'(i) == grant_id_q) begin
                    rsp_valid[i] = 1'b1;
                end
            end
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_bs_alu_arbiter.sv
// Bench for bs_alu_arbiter: transaction-level model checked every cycle plus directed
// scenarios with hand-computed results, latencies and grant orders.
module tb_bs_alu_arbiter;

    localparam int NREQ    = 2;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;

    logic              clk;
    logic              rstn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_result;
    logic              rsp_err;
    logic              alu_start;
    logic [3:0]        alu_op;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [W-1:0]      alu_result;
    logic              alu_done;
    logic              busy;
    logic [1:0]        grant_id;

    bs_alu_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_done(alu_done),
        .busy(busy), .grant_id(grant_id)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int alu_lat = 1;       // 0 = the ALU never signals done
    bit stale_mode = 0;    // drive done high whenever no op is pending

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a ^ b;
            default: return a | b;
        endcase
    endfunction

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // ALU stand-in: done alu_lat cycles after the start cycle, junk result otherwise.
    initial begin : alu_model
        bit pending;
        int start_c;
        logic [W-1:0] res;
        pending = 0; start_c = 0; res = '0;
        alu_done = 1'b0;
        alu_result = '0;
        forever begin
            @(negedge clk);
            if (!rstn) pending = 0;
            else if (alu_start) begin
                pending = 1; start_c = cyc; res = alu_fn(alu_op, alu_a, alu_b);
            end
            @(posedge clk);
            #1;
            if (pending && alu_lat != 0 && cyc == start_c + alu_lat) begin
                alu_done = 1'b1; alu_result = res; pending = 0;
            end else begin
                alu_done = !pending && stale_mode;
                alu_result = 32'hBAD0_0000 | 32'(cyc);
            end
        end
    end

    // Transaction-level reference: owner, handshake cycle, response cycle.
    initial begin : model
        int m_last, m_owner, m_gid, m_hs, m_resp, win;
        bit m_txn;
        logic [3:0] m_op;
        logic [W-1:0] m_a, m_b, m_res;
        logic m_err;
        logic [63:0] exp_rr, exp_rv;
        m_last = NREQ - 1; m_owner = 0; m_gid = 0; m_hs = 0; m_resp = -1; m_txn = 0;
        m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                chk("rst_req_ready", 64'(req_ready), 0);
                chk("rst_rsp_valid", 64'(rsp_valid), 0);
                chk("rst_alu_start", 64'(alu_start), 0);
                chk("rst_busy", 64'(busy), 0);
                chk("rst_grant_id", 64'(grant_id), 0);
                chk("rst_alu_op", 64'(alu_op), 0);
                chk("rst_alu_a", 64'(alu_a), 0);
                chk("rst_alu_b", 64'(alu_b), 0);
                chk("rst_rsp_result", 64'(rsp_result), 0);
                chk("rst_rsp_err", 64'(rsp_err), 0);
                m_last = NREQ - 1; m_gid = 0; m_txn = 0; m_resp = -1;
            end else begin
                win = rr_pick(m_last, req_valid);
                exp_rr = (!m_txn && win >= 0) ? (64'(1) << win) : 64'(0);
                exp_rv = (m_txn && m_resp >= 0 && cyc >= m_resp) ? (64'(1) << m_owner) : 64'(0);
                chk("m_req_ready", 64'(req_ready), exp_rr);
                chk("m_alu_start", 64'(alu_start), 64'(m_txn && cyc == m_hs + 1));
                chk("m_busy", 64'(busy), 64'(m_txn));
                chk("m_grant_id", 64'(grant_id), 64'(m_gid));
                chk("m_rsp_valid", 64'(rsp_valid), exp_rv);
                if (exp_rv != 0) begin
                    chk("m_rsp_result", 64'(rsp_result), 64'(m_res));
                    chk("m_rsp_err", 64'(rsp_err), 64'(m_err));
                end
                if (m_txn) begin
                    chk("m_alu_op", 64'(alu_op), 64'(m_op));
                    chk("m_alu_a", 64'(alu_a), 64'(m_a));
                    chk("m_alu_b", 64'(alu_b), 64'(m_b));
                end
                if (m_txn) begin
                    if (m_resp < 0 && cyc > m_hs + 1) begin
                        if (alu_done) begin
                            m_resp = cyc + 1; m_res = alu_result; m_err = 1'b0;
                        end else if (cyc == m_hs + 1 + TIMEOUT) begin
                            m_resp = cyc + 1; m_res = '0; m_err = 1'b1;
                        end
                    end else if (exp_rv != 0 && rsp_ready[m_owner]) begin
                        m_txn = 0;
                    end
                end else if (win >= 0) begin
                    m_txn = 1; m_owner = win; m_last = win; m_gid = win;
                    m_hs = cyc; m_resp = -1;
                    m_op = req_op[4*win +: 4];
                    m_a  = req_a[W*win +: W];
                    m_b  = req_b[W*win +: W];
                end
            end
        end
    end

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(output int who, output int t);
        who = -1; t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((req_ready & req_valid) != 0) begin
                for (int j = 0; j < NREQ; j++) if (req_ready[j]) who = j;
                t = cyc;
                return;
            end
        end
        chk("handshake_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rsp_valid != 0) begin
                t = cyc;
                return;
            end
        end
        chk("response_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && rsp_valid == 0) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        step();
        rstn = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
    endtask

    initial begin : stim
        int who, t, r, n_start, s_cyc, n_g;
        int g[4];
        rstn = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(req_ready), 0);
        chk("post_rst_busy", 64'(busy), 0);
        chk("post_rst_grant_id", 64'(grant_id), 0);

        // Single add on requester 0, L=33
        step();
        alu_lat = 33; rsp_ready = 2'b11;
        req_op[3:0] = 4'd0; req_a[31:0] = 32'd5; req_b[31:0] = 32'd7; req_valid = 2'b01;
        wait_hs(who, t);
        chk("t1_winner", 64'(who), 0);
        step();
        req_valid = 2'b00;
        n_start = 0; s_cyc = -1; r = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (alu_start) begin n_start++; s_cyc = cyc; end
            if (rsp_valid != 0) begin r = cyc; break; end
        end
        chk("t1_start_count", 64'(n_start), 1);
        chk("t1_start_cycle", 64'(s_cyc), 64'(t + 1));
        chk("t1_rsp_cycle", 64'(r), 64'(t + 35));
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_result", 64'(rsp_result), 64'd12);
        chk("t1_rsp_err", 64'(rsp_err), 0);
        wait_idle();

        // Two requesters continuously valid from reset: alternate grants
        do_reset();
        alu_lat = 3;
        req_op[3:0] = 4'd0; req_a[31:0]  = 32'd100; req_b[31:0]  = 32'd23;
        req_op[7:4] = 4'd1; req_a[63:32] = 32'd100; req_b[63:32] = 32'd23;
        req_valid = 2'b11;
        n_g = 0;
        for (int i = 0; i < 200 && n_g < 4; i++) begin
            @(negedge clk);
            chk("t2_ready_onehot", 64'($countones(req_ready) <= 1), 1);
            if ((req_ready & req_valid) != 0) begin
                g[n_g] = req_ready[1] ? 1 : 0;
                n_g++;
            end
            if (rsp_valid == 2'b01) chk("t2_result_r0", 64'(rsp_result), 64'd123);
            if (rsp_valid == 2'b10) chk("t2_result_r1", 64'(rsp_result), 64'd77);
        end
        chk("t2_grant_count", 64'(n_g), 4);
        for (int k = 0; k < 4; k++) chk("t2_grant_seq", 64'(g[k]), 64'(k % 2));
        step();
        req_valid = 2'b00;
        wait_idle();

        // Owner 1 stalls its response while requester 0 waits
        step();
        alu_lat = 4; rsp_ready = 2'b00;
        req_op[7:4] = 4'd2; req_a[63:32] = 32'hF0F0; req_b[63:32] = 32'hFF00;
        req_op[3:0] = 4'd3; req_a[31:0]  = 32'h1234; req_b[31:0]  = 32'h00FF;
        req_valid = 2'b10;
        wait_hs(who, t);
        chk("t3_owner", 64'(who), 1);
        step();
        req_valid = 2'b11;
        wait_rsp(r);
        chk("t3_rsp_cycle", 64'(r), 64'(t + 6));
        step();
        rsp_ready = 2'b01;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 64'(rsp_valid), 64'h2);
            chk("t3_hold_result", 64'(rsp_result), 64'hF000);
            chk("t3_no_ready0", 64'(req_ready), 0);
        end
        step();
        rsp_ready = 2'b11;
        wait_hs(who, t);
        chk("t3_next_winner", 64'(who), 0);
        step();
        req_valid = 2'b00;
        wait_idle();

        // Timeout, then a normal op
        step();
        alu_lat = 0;
        req_op[3:0] = 4'd0; req_a[31:0] = 32'd1; req_b[31:0] = 32'd2; req_valid = 2'b01;
        wait_hs(who, t);
        step();
        req_valid = 2'b00;
        wait_rsp(r);
        chk("t4_timeout_cycle", 64'(r), 64'(t + 66));
        chk("t4_timeout_err", 64'(rsp_err), 1);
        chk("t4_timeout_result", 64'(rsp_result), 0);
        wait_idle();
        step();
        alu_lat = 2; req_valid = 2'b01;
        wait_hs(who, t);
        step();
        req_valid = 2'b00;
        wait_rsp(r);
        chk("t4_after_cycle", 64'(r), 64'(t + 4));
        chk("t4_after_err", 64'(rsp_err), 0);
        chk("t4_after_result", 64'(rsp_result), 64'd3);
        wait_idle();

        // Stale done during the start cycle, real done at L=5
        step();
        stale_mode = 1; alu_lat = 5;
        req_op[7:4] = 4'd1; req_a[63:32] = 32'd50; req_b[63:32] = 32'd8; req_valid = 2'b10;
        wait_hs(who, t);
        step();
        req_valid = 2'b00;
        wait_rsp(r);
        chk("t5_rsp_cycle", 64'(r), 64'(t + 7));
        chk("t5_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("t5_rsp_result", 64'(rsp_result), 64'd42);
        chk("t5_rsp_err", 64'(rsp_err), 0);
        wait_idle();
        step();
        stale_mode = 0;

        // Asynchronous reset while requester 1 is waiting on the ALU
        alu_lat = 0;
        req_valid = 2'b10;
        wait_hs(who, t);
        chk("t6_owner", 64'(who), 1);
        repeat (5) @(posedge clk);
        #3;
        chk("t6_busy_before", 64'(busy), 1);
        rstn = 1'b0;
        #1;
        chk("t6_async_busy", 64'(busy), 0);
        chk("t6_async_grant", 64'(grant_id), 0);
        chk("t6_async_rsp_valid", 64'(rsp_valid), 0);
        chk("t6_async_alu_start", 64'(alu_start), 0);
        chk("t6_async_alu_a", 64'(alu_a), 0);
        req_valid = 2'b11;
        #1;
        chk("t6_rst_req_ready", 64'(req_ready), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        alu_lat = 2;
        wait_hs(who, t);
        chk("t6_first_after_rst", 64'(who), 0);
        step();
        req_valid = 2'b00;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bs_alu_arbiter.md
Name: bs_alu_arbiter

Overview:
Shares the single bit-serial ALU between NREQ independent requesters, such as the core FSM and a multiply/divide sequencer or debug unit. It uses round-robin arbitration with a valid/ready handshake on both request and response. It issues one ALU operation at a time: a one-cycle start pulse, then it holds the operands until done. A watchdog aborts operations whose done never arrives. The block sits between the requesters and the bit-serial ALU's start/op/a/b/result/done interface.

Parameters:
NREQ, 2, number of requesters (legal 2..4)
W, 32, operand/result width
TIMEOUT, 64, maximum WAIT cycles before abort (legal >=2)

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept (one-hot or zero)
req_op  input  4*NREQ  ALU op, requester i at [4i+3:4i]
req_a  input  W*NREQ  operand A, requester i at [W*i+W-1:W*i]
req_b  input  W*NREQ  operand B, same packing
rsp_valid  output  NREQ  response valid, one-hot to the owner
rsp_ready  input  NREQ  per-requester response accept
rsp_result  output  W  result, shared by all requesters
rsp_err  output  1  1 = op aborted by timeout
alu_start  output  1  one-cycle start pulse to the ALU
alu_op  output  4  op to the ALU
alu_a  output  W  operand A to the ALU
alu_b  output  W  operand B to the ALU
alu_result  input  W  ALU result
alu_done  input  1  ALU done
busy  output  1  high in every state except IDLE
grant_id  output  2  index of the current or last owner

Behaviour:
- Reset values: state=IDLE; all outputs 0; rr pointer last=NREQ-1, so requester 0 wins first.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE arbitration:
  - Candidates are scanned from (last+1) mod NREQ upward, wrapping; the first with req_valid=1 wins.
  - req_ready is combinational: the winner's one-hot, asserted only in IDLE; zero in all other states.
  - Handshake occurs at req_valid&req_ready in cycle T. On handshake:
    - latch op/a/b into alu_op/alu_a/alu_b;
    - set grant_id=winner and last=winner;
    - go to ISSUE.
  - With no valid requests, stay in IDLE.
- ISSUE (T+1):
  - alu_start=1 for exactly this cycle; alu_op/a/b are already stable.
  - alu_done is ignored in this cycle (stale done from the previous op).
  - Clear the timer; go to WAIT.
- WAIT:
  - alu_start=0; alu_op/a/b are held unchanged.
  - If alu_done=1: capture rsp_result=alu_result, rsp_err=0, go to RESP.
  - Else timer++. When timer reaches TIMEOUT-1 without done: rsp_result=0, rsp_err=1, go to RESP.
  - done takes priority over timeout when both occur in the same cycle.
- RESP:
  - rsp_valid[grant_id]=1; rsp_result and rsp_err are held stable.
  - When rsp_ready[grant_id]=1, clear rsp_valid and go to IDLE.
  - rsp_ready of non-owners is ignored.
  - New requests are not accepted until the next IDLE.
- Latency: if the ALU asserts done L cycles after the start cycle (L>=1), rsp_valid rises at T+2+L. Minimum spacing between grants is L+3 cycles with rsp_ready held at 1.
- Fairness: once granted, a requester loses priority to every other pending requester. Two requesters held continuously valid alternate grants.
- A requester deasserting req_valid while not granted is legal; nothing is latched.
- Reset mid-operation: return immediately to IDLE, discard the in-flight op, drop alu_start/rsp_valid, reset last to NREQ-1. The ALU shares rstn.
- grant_id and busy are registered. grant_id updates only on handshake.

Test Plan:
- Requester 0: op=0, a=5, b=7; ALU model L=33 -> exactly one alu_start pulse at T+1; rsp_valid=01 at T+35, rsp_result=12, rsp_err=0.
- Both requesters held valid with distinct ops from reset, rsp_ready=1 -> grant sequence 0,1,0,1; each result routed to the correct rsp_valid bit; req_ready never two-hot.
- Requester 1 owner, rsp_ready[1]=0 for 10 cycles, req_valid[0]=1 throughout -> rsp_valid/result stable for 10 cycles; req_ready[0]=0 until requester 1 accepts; requester 0 granted in the next IDLE.
- ALU model never asserts done, TIMEOUT=64 -> RESP after 64 WAIT cycles with rsp_err=1, rsp_result=0; a following request completes normally with rsp_err=0.
- alu_done held high during the ISSUE cycle (stale) and then low until L=5 -> done in the ISSUE cycle ignored; response reflects the done at L=5.
- rstn asserted in WAIT while requester 1 owns the ALU -> all outputs 0 asynchronously; after release with both requesters valid, requester 0 is granted first.
